// File: rtl/cla_pkg.sv
// ============================================================================
//  Module      : cla_pkg
//  Description : Shared types and helpers for the serial CLA subtractor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cla_pkg;

    // Control states of the serial subtractor
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cla_sub_state_t;

    // Integer ceiling division, used to size the slice count
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// ============================================================================
//  Module      : cla_slice
//  Description : SLICE-bit carry-lookahead adder slice (purely combinational).
//                Every carry is formed directly from generate/propagate terms
//                and the slice carry-in rather than rippling bit to bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_slice #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout
);

    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_p;
    logic [SLICE:0]   w_c;

    // Flattened lookahead: carry into bit k is
    // g[k-1] | p[k-1]g[k-2] | ... | p[k-1..0]cin
    function automatic logic carry_into(
        input logic [SLICE-1:0] g,
        input logic [SLICE-1:0] p,
        input logic             cin,
        input int               k
    );
        logic v_c;
        logic v_prod;
        v_c    = 1'b0;
        v_prod = 1'b1;
        for (int j = k - 1; j >= 0; j--) begin
            v_c    = v_c | (v_prod & g[j]);
            v_prod = v_prod & p[j];
        end
        return v_c | (v_prod & cin);
    endfunction

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    for (genvar k = 0; k <= SLICE; k++) begin : g_carry
        assign w_c[k] = carry_into(w_g, w_p, i_cin, k);
    end

    assign o_sum  = w_p ^ w_c[SLICE-1:0];
    assign o_cout = w_c[SLICE];

endmodule

`default_nettype wire

// File: rtl/cla_serial_subtractor.sv
// ============================================================================
//  Module      : cla_serial_subtractor
//  Description : Serial subtractor recovering an addend from a CLA sum:
//                o_diff = i_minuend - i_subtrahend, SLICE bits per cycle
//                through one shared lookahead slice, borrow carried between
//                slices. Valid/ready handshake on input and output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_serial_subtractor
    import cla_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int SLICE = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH:0]   i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_overflow
);

    localparam int c_N      = WIDTH + 1;
    localparam int c_NSLICE = ceil_div(c_N, SLICE);
    localparam int c_NPAD   = c_NSLICE * SLICE;
    localparam int c_IDX_W  = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NSLICE - 1);

    cla_sub_state_t      r_state;
    logic [c_NPAD-1:0]   r_a;
    logic [c_NPAD-1:0]   r_b;
    logic [c_NPAD-1:0]   r_res;
    logic [c_IDX_W-1:0]  r_idx;
    logic                r_carry;
    logic                r_valid;
    logic [WIDTH-1:0]    r_diff;
    logic                r_borrow;
    logic                r_overflow;

    logic [SLICE-1:0]        w_sum;
    logic                    w_cout;
    logic [c_NPAD+SLICE-1:0] w_res_cat;
    logic [c_NPAD-1:0]       w_res_next;

    // Operands are consumed LSB-first: the low SLICE bits of each shifting
    // capture register always hold the slice being processed. The inverted
    // subtrahend is padded with ones, so the padded bits just pass the carry
    // through and the slice carry-out equals the carry out of bit N-1.
    cla_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .i_a    (r_a[SLICE-1:0]),
        .i_b    (r_b[SLICE-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // New slice bits enter at the top; after the last slice the result is aligned
    assign w_res_cat  = {w_sum, r_res};
    assign w_res_next = w_res_cat[c_NPAD+SLICE-1:SLICE];

    assign o_ready    = (r_state == IDLE) && !i_rst;
    assign o_valid    = r_valid;
    assign o_diff     = r_diff;
    assign o_borrow   = r_borrow;
    assign o_overflow = r_overflow;

    // Handshake FSM, operand capture, slice sequencing and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b1;
            r_valid    <= 1'b0;
            r_diff     <= '0;
            r_borrow   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_a     <= c_NPAD'(i_minuend);
                        r_b     <= ~c_NPAD'(i_subtrahend);
                        r_carry <= 1'b1;
                        r_idx   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> SLICE;
                    r_b     <= r_b >> SLICE;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_state    <= DONE;
                        r_valid    <= 1'b1;
                        r_diff     <= w_res_next[WIDTH-1:0];
                        r_borrow   <= !w_cout;
                        r_overflow <= w_cout & w_res_next[WIDTH];
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_state    <= IDLE;
                        r_valid    <= 1'b0;
                        r_diff     <= '0;
                        r_borrow   <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
